// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation select and sequencer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational ripple of full-adder / full-subtractor cells over one operand slice.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] a_s,
    input  logic [BITS_PER_CYCLE-1:0] b_s,
    input  logic                      cin,
    input  logic                      op,
    output logic [BITS_PER_CYCLE-1:0] r_s,
    output logic                      cout
);

    logic [BITS_PER_CYCLE:0] chain;

    assign chain[0] = cin;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        logic p;
        assign p      = a_s[i] ^ b_s[i];
        assign r_s[i] = p ^ chain[i];
        // chain carries the carry for add and the borrow for subtract
        assign chain[i+1] = (op == OP_SUB)
                          ? ((~a_s[i] & b_s[i]) | (~p & chain[i]))
                          : ((a_s[i] & b_s[i])  | (p & chain[i]));
    end

    assign cout = chain[BITS_PER_CYCLE];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor, BITS_PER_CYCLE bits per clock LSB first; SERIAL_ADDSUB_OVF_EN adds signed overflow.
// Latency: start accepted in cycle 0 -> busy cycles 1..N -> done pulse cycle N+1 (N = WIDTH/BITS_PER_CYCLE).
// Backpressure: start is only honoured in IDLE; requests during RUN/DONE are dropped, not queued.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, next_state;

    logic [CW-1:0]             cnt;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic                      op_q;
    logic                      carry;
    logic [BITS_PER_CYCLE-1:0] r_s;
    logic                      c_s;
    logic                      last_slice;
    logic                      accept;

    assign last_slice = (cnt == LAST);
    assign accept     = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    addsub_slice #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_slice (
        .a_s  (a_sh[BITS_PER_CYCLE-1:0]),
        .b_s  (b_sh[BITS_PER_CYCLE-1:0]),
        .cin  (carry),
        .op   (op_q),
        .r_s  (r_s),
        .cout (c_s)
    );

    // Operands shift down so the current slice always sits at bit 0;
    // result fills from the top so the first slice lands at the LSB after N shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            op_q   <= OP_ADD;
            carry  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            cnt   <= '0;
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            carry <= 1'b0;
        end else if (state == ST_RUN) begin
            result <= WIDTH'({r_s, result} >> BITS_PER_CYCLE);
            a_sh   <= a_sh >> BITS_PER_CYCLE;
            b_sh   <= b_sh >> BITS_PER_CYCLE;
            carry  <= c_s;
            cnt    <= last_slice ? '0 : cnt + 1'b1;
        end
    end

    assign cout = carry;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;
    logic ovf_calc;

    // Final slice's top bit is the result MSB, so the flag is ready alongside done.
    always_comb begin
        ovf_calc = 1'b0;
        if (op_q == OP_SUB) begin
            ovf_calc = (a_msb != b_msb) && (r_s[BITS_PER_CYCLE-1] != a_msb);
        end else begin
            ovf_calc = (a_msb == b_msb) && (r_s[BITS_PER_CYCLE-1] != a_msb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if ((state == ST_RUN) && last_slice) begin
            ovf_q <= ovf_calc;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
